dmem_responder: RTL and testbench

Data-memory responder for the core's load/store unit: accepts one request at a time over a valid/ready handshake, performs a byte/half/word read or write on an internal synchronous byte-addressed RAM of 2**addr_width_DMEM bytes, and returns a response over a second valid/ready handshake. It is the memory-side end of the core's data port and sits between the LSU and the DMEM array. Its address space matches the stack pointer's reset value, so the stack grows down from the top of this RAM.

---
 rtl/dmem_responder_if.sv | 29 ++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between the LSU (master) and the DMEM responder (slave).
// Two independent valid/ready handshakes: one for requests, one for responses.
interface dmem_responder_if #(
    parameter int bits = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [bits-1:0] req_addr;
    logic [bits-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [bits-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, byte/half/word access to an
// internal synchronous RAM. Optional macro DMEM_MISALIGN_TRAP_EN makes
// misaligned half/word accesses fault instead of being force-aligned.
module dmem_responder #(
    parameter int bits            = 32,
    parameter int addr_width_DMEM = 10
) (
    input logic            clk,
    input logic            async_reset,
    dmem_responder_if.slave bus
);
    localparam int WORDS = 2 ** (addr_width_DMEM - 2);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]      state;
    logic            we_q;
    logic            uns_q;
    logic [1:0]      size_q;
    logic [bits-1:0] addr_q;
    logic [bits-1:0] wdata_q;
    logic            err_q;
    logic [bits-1:0] rd_q;

    logic [bits-1:0] mem [WORDS];

    logic                       fault;
    logic [1:0]                 lo;
    logic [3:0]                 be;
    logic [bits-1:0]            wlanes;
    logic [addr_width_DMEM-3:0] widx;
    logic [bits-1:0]            shifted;
    logic [bits-1:0]            ext;

    // Fault detection, lane alignment, byte enables and lane replication
    always_comb begin
        fault = (|addr_q[bits-1:addr_width_DMEM]) || (size_q == 2'd3);
        lo    = addr_q[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        if (size_q == 2'd1 && addr_q[0])
            fault = 1'b1;
        if (size_q == 2'd2 && (|addr_q[1:0]))
            fault = 1'b1;
`else
        if (size_q == 2'd1)
            lo[0] = 1'b0;
        if (size_q == 2'd2)
            lo = 2'b00;
`endif
        widx = addr_q[addr_width_DMEM-1:2];
        unique case (size_q)
            2'd0: begin
                be     = 4'b0001 << lo;
                wlanes = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be     = lo[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = wdata_q;
            end
        endcase
    end

    // Request latch and IDLE -> ACCESS -> RESP sequencing
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        uns_q   <= bus.req_unsigned;
                        size_q  <= bus.req_size;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    err_q <= fault;
                    state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port: lane-masked write or synchronous word read, never on a fault
    always_ff @(posedge clk) begin
        if (state == ACCESS && !fault) begin
            if (we_q) begin
                for (int i = 0; i < 4; i++)
                    if (be[i])
                        mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
            end else begin
                rd_q <= mem[widx];
            end
        end
    end

    // Load data alignment and sign/zero extension
    always_comb begin
        shifted = rd_q >> {lo, 3'b000};
        unique case (size_q)
            2'd0:
                ext = uns_q ? {{(bits-8){1'b0}}, shifted[7:0]}
                            : {{(bits-8){shifted[7]}}, shifted[7:0]};
            2'd1:
                ext = uns_q ? {{(bits-16){1'b0}}, shifted[15:0]}
                            : {{(bits-16){shifted[15]}}, shifted[15:0]};
            default:
                ext = shifted;
        endcase
    end

    assign bus.req_ready = (state == IDLE) && !async_reset;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_err   = (state == RESP) && err_q;
    assign bus.rsp_rdata = (state == RESP && !err_q && !we_q) ? ext : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder with a byte-array reference model.
// Honors DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic async_reset;

    always #5 clk = ~clk;

    dmem_responder_if #(.bits(32)) bus ();

    dmem_responder #(
        .bits(32),
        .addr_width_DMEM(10)
    ) dut (
        .clk(clk),
        .async_reset(async_reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd;
    logic        last_err;
    byte unsigned ram_m [1024];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference: byte array, natural alignment, explicit extension
    task automatic ref_op(input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] wd, output logic err,
                          output logic [31:0] rd);
        int n;
        int a;
        logic [31:0] v;
        rd  = 32'd0;
        err = (addr >= 32'd1024) || (size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
        if (size == 2'd1 && addr % 2 != 0) err = 1'b1;
        if (size == 2'd2 && addr % 4 != 0) err = 1'b1;
`endif
        if (err) return;
        n = 1 << size;
        a = int'(addr) - int'(addr) % n;
        if (we) begin
            for (int i = 0; i < n; i++)
                ram_m[a+i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++)
                v |= 32'(ram_m[a+i]) << (8 * i);
            if (n < 4 && !uns && v[8*n-1])
                v |= ~((32'd1 << (8 * n)) - 32'd1);
            rd = v;
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold);
        logic e_err;
        logic [31:0] e_rd;
        int w;
        ref_op(we, size, uns, addr, wd, e_err, e_rd);
        @(negedge clk);
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) check("req_ready_wait", 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.rsp_ready    = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        check("access_req_ready", 32'(bus.req_ready), 32'd0);
        check("access_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_ready", 32'(bus.req_ready), 32'd0);
            check("hold_rdata", bus.rsp_rdata, e_rd);
        end
        check("rsp_rdata", bus.rsp_rdata, e_rd);
        check("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        last_rd  = bus.rsp_rdata;
        last_err = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);
        check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        logic e_err;
        logic [31:0] prior;
        async_reset      = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.rsp_ready    = 1'b0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        async_reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("post_rst_rdata", bus.rsp_rdata, 32'd0);
        check("post_rst_err", 32'(bus.rsp_err), 32'd0);

        for (int i = 0; i < 256; i++)
            xact(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0);

        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        check("st_word_rdata", last_rd, 32'd0);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0);
        check("ld_word", last_rd, 32'hDEADBEEF);
        xact(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 0);
        check("ld_sbyte", last_rd, 32'hFFFFFFDE);
        xact(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0);
        check("ld_ubyte", last_rd, 32'h000000DE);
        xact(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, 0);
        check("ld_shalf", last_rd, 32'hFFFFBEEF);
        xact(1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 0);
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0);
        check("ld_merged", last_rd, 32'h1234BEEF);

        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5);
        check("bp_rdata", last_rd, 32'h1234BEEF);

        xact(1'b1, 2'd2, 1'b0, 32'd1024, 32'h55555555, 0);
        check("oor_err", 32'(last_err), 32'd1);
        xact(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 0);
        xact(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 0);
        check("size3_err", 32'(last_err), 32'd1);

        xact(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        check("mis_err", 32'(last_err), 32'd1);
        check("mis_rdata", last_rd, 32'd0);
`else
        check("mis_err", 32'(last_err), 32'd0);
        check("mis_rdata", last_rd, 32'h1234BEEF);
`endif

        ref_op(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, e_err, prior);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd2;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hAAAAAAAA;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("mid_in_access", 32'(bus.req_ready), 32'd0);
        async_reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_err", 32'(bus.rsp_err), 32'd0);
        check("mid_rst_rdata", bus.rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst_hold", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        async_reset = 1'b0;
        #1;
        check("mid_rel_ready", 32'(bus.req_ready), 32'd1);
        xact(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 0);
        check("mid_prior", last_rd, prior);

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            if ($urandom_range(0, 15) == 0)
                a = 32'd1024 + $urandom_range(0, 4095);
            else
                a = $urandom_range(0, 1023);
            xact(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                 int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
